// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared types and constants for the optical pulse sequencer.
//   ps_state_e   - sequencer state encoding
//   Def*         - default parameter values for pulse_seq
//   TmrW / CntW  - timer and pulse-counter widths
//   is_train()   - true for the states in which a train is in progress
//   ld_val()     - timer load value that yields an n-cycle state dwell
package pulse_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDelay   = 3'd1,
    StHigh    = 3'd2,
    StLow     = 3'd3,
    StDone    = 3'd4,
    StWaitRel = 3'd5
  } ps_state_e;

  localparam int unsigned DefDelay    = 1000;
  localparam int unsigned DefPulseW   = 50;
  localparam int unsigned DefPulseGap = 450;
  localparam int unsigned DefPulseNum = 8;

  localparam int unsigned TmrW = 32;
  localparam int unsigned CntW = 8;

  function automatic logic is_train(ps_state_e s);
    return (s == StDelay) || (s == StHigh) || (s == StLow);
  endfunction

  // The timer is checked for zero one cycle after each load, so an n-cycle
  // dwell needs n-1 loaded; n=0 is only legal for DELAY, which bypasses it.
  function automatic logic [TmrW-1:0] ld_val(int unsigned n);
    return (n == 0) ? '0 : TmrW'(n - 1);
  endfunction

endpackage

// File: rtl/pulse_seq_if.sv
// pulse_seq_if: start/status bundle of the pulse sequencer.
//   ps_start - generation-enable level (master -> slave)
//   ps_o     - optical pulse drive, high = LED on
//   ps_busy  - train in progress
//   ps_done  - one-cycle strobe, train completed
//   ps_abort - one-cycle strobe, train cut short
//   ps_cnt   - pulses emitted in the current/last train
// Modports: slave = sequencer side, master = start block / observer side.
interface pulse_seq_if;
  import pulse_seq_pkg::*;

  logic            ps_start;
  logic            ps_o;
  logic            ps_busy;
  logic            ps_done;
  logic            ps_abort;
  logic [CntW-1:0] ps_cnt;

  modport slave (
    input  ps_start,
    output ps_o,
    output ps_busy,
    output ps_done,
    output ps_abort,
    output ps_cnt
  );

  modport master (
    output ps_start,
    input  ps_o,
    input  ps_busy,
    input  ps_done,
    input  ps_abort,
    input  ps_cnt
  );

endinterface

// File: rtl/pulse_seq_tmr.sv
// pulse_seq_tmr: loadable 32-bit down-counter with zero flag.
//   ps_clk   - clock, rising edge
//   ps_rst   - asynchronous active-high reset, clears the count
//   load     - load load_val this cycle (wins over counting)
//   load_val - value to load
//   zero     - count is zero; counting stops there
module pulse_seq_tmr
  import pulse_seq_pkg::*;
(
  input  logic            ps_clk,
  input  logic            ps_rst,
  input  logic            load,
  input  logic [TmrW-1:0] load_val,
  output logic            zero
);

  localparam logic [TmrW-1:0] One = TmrW'(1);

  logic [TmrW-1:0] count_q;

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - One;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_seq.sv
// pulse_seq: optical pulse-train sequencer.
// On a rising edge of ps_start seen in IDLE, waits DELAY cycles, then emits
// PULSE_NUM pulses of PULSE_W high cycles separated by PULSE_GAP low cycles,
// strobes ps_done and waits for ps_start to be released. ps_start falling
// during a train aborts it (ps_abort strobe). All outputs are registered.
//   ps_clk - clock, rising edge
//   ps_rst - asynchronous active-high reset
//   bus    - pulse_seq_if.slave (ps_start in; ps_o/busy/done/abort/cnt out)
module pulse_seq
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DELAY     = DefDelay,
  parameter int unsigned PULSE_W   = DefPulseW,
  parameter int unsigned PULSE_GAP = DefPulseGap,
  parameter int unsigned PULSE_NUM = DefPulseNum
) (
  input  logic        ps_clk,
  input  logic        ps_rst,
  pulse_seq_if.slave  bus
);

  localparam logic [TmrW-1:0] LdDelay = ld_val(DELAY);
  localparam logic [TmrW-1:0] LdHigh  = ld_val(PULSE_W);
  localparam logic [TmrW-1:0] LdGap   = ld_val(PULSE_GAP);
  localparam logic [CntW-1:0] NumCnt  = CntW'(PULSE_NUM);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  ps_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_qq;
  logic            idle_prev_q;
  logic            o_q, busy_q, done_q, abort_q;
  logic            abort_d;
  logic            start_ev;
  logic            tmr_load;
  logic [TmrW-1:0] tmr_val;
  logic            tmr_zero;

  pulse_seq_tmr u_tmr (
    .ps_clk   (ps_clk),
    .ps_rst   (ps_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // start_q/start_qq reset high so a level held through reset is not a start.
  // idle_prev_q remembers whether the low sample preceding a rise was taken in
  // IDLE; a rise whose low phase aborted a train or released WAIT_REL is not a
  // fresh start.
  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      start_q     <= 1'b1;
      start_qq    <= 1'b1;
      idle_prev_q <= 1'b1;
    end else begin
      start_q     <= bus.ps_start;
      start_qq    <= start_q;
      idle_prev_q <= (state_q == StIdle);
    end
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= (state_d == StHigh);
      busy_q  <= is_train(state_d);
      done_q  <= (state_d == StDone);
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    start_ev = start_q && !start_qq && idle_prev_q;

    // Abort is checked first so it wins over any timer expiry.
    if (is_train(state_q) && !start_q) begin
      state_d = StIdle;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ev) begin
            tmr_load = 1'b1;
            if (DELAY == 0) begin
              state_d = StHigh;
              cnt_d   = CntOne;
              tmr_val = LdHigh;
            end else begin
              state_d = StDelay;
              cnt_d   = '0;
              tmr_val = LdDelay;
            end
          end
        end
        StDelay, StLow: begin
          if (tmr_zero) begin
            state_d  = StHigh;
            cnt_d    = cnt_q + CntOne;
            tmr_load = 1'b1;
            tmr_val  = LdHigh;
          end
        end
        StHigh: begin
          if (tmr_zero) begin
            if (cnt_q == NumCnt) begin
              state_d = StDone;
            end else begin
              state_d  = StLow;
              tmr_load = 1'b1;
              tmr_val  = LdGap;
            end
          end
        end
        StDone: begin
          state_d = StWaitRel;
        end
        StWaitRel: begin
          if (!start_q) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign bus.ps_o     = o_q;
  assign bus.ps_busy  = busy_q;
  assign bus.ps_done  = done_q;
  assign bus.ps_abort = abort_q;
  assign bus.ps_cnt   = cnt_q;

endmodule

// File: doc/pulse_seq.md
PULSE_SEQ -- requirements
Module: pulse_seq

Interface
REQ-001 Parameter DELAY, default 1000, cycles from start detection to first pulse (0 allowed).
REQ-002 Parameter PULSE_W, default 50, high cycles per light pulse (>=1).
REQ-003 Parameter PULSE_GAP, default 450, low cycles between pulses (>=1).
REQ-004 Parameter PULSE_NUM, default 8, pulses per train (1..255).
REQ-005 ps_clk  in  1  single system clock; all logic on rising edge.
REQ-006 ps_rst  in  1  reset, asynchronous, active-high.
REQ-007 ps_start  in  1  generation-enable level from the start block, same clock domain, high = window open.
REQ-008 ps_o  out  1  optical pulse drive, high = LED on.
REQ-009 ps_busy  out  1  high while a train is in progress (DELAY, HIGH, LOW states).
REQ-010 ps_done  out  1  one-cycle strobe, train completed normally.
REQ-011 ps_abort  out  1  one-cycle strobe, train cut short by ps_start falling.
REQ-012 ps_cnt  out  8  pulses emitted in current/last train.

Function
REQ-013 States SHALL be IDLE, DELAY, HIGH, LOW, DONE, WAIT_REL.
REQ-014 Start event = rising edge of ps_start (registered previous value low, current high); only accepted in IDLE.
REQ-015 IDLE + start event: enter DELAY with timer loaded DELAY; if DELAY=0 enter HIGH directly; ps_cnt cleared to 0.
REQ-016 ps_o SHALL rise exactly DELAY+1 cycles after the clock edge that samples the start event.
REQ-017 HIGH: ps_o=1 for exactly PULSE_W cycles; ps_cnt increments on HIGH entry.
REQ-018 Leaving HIGH with ps_cnt<PULSE_NUM: LOW for exactly PULSE_GAP cycles, then HIGH.
REQ-019 Leaving HIGH with ps_cnt==PULSE_NUM: DONE for one cycle (ps_done=1, ps_o=0), no trailing gap, then WAIT_REL.
REQ-020 WAIT_REL: hold until ps_start low, then IDLE; a level held high SHALL never retrigger.
REQ-021 ps_start low while in DELAY/HIGH/LOW: next cycle ps_o=0, ps_abort=1 for one cycle, state IDLE, ps_cnt holds value.
REQ-022 Abort takes priority over any timer expiry in the same cycle.
REQ-023 ps_busy=1 exactly in DELAY, HIGH, LOW; ps_o=1 only in HIGH; ps_done and ps_abort never both high.
REQ-024 Timer is 32-bit down-counter; counts wrap-free since loads never exceed parameter values.
REQ-025 All outputs registered; no combinational path ps_start to any output.

Reset
REQ-026 ps_rst high: state IDLE, ps_o=0, ps_busy=0, ps_done=0, ps_abort=0, ps_cnt=0, timer=0, registered ps_start=1 (no false start on release with ps_start high).
REQ-027 Reset mid-train: ps_o SHALL drop asynchronously; after release, no train until a fresh ps_start rising edge.

Structure
REQ-028 Package pulse_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-029 One sub-module pulse_seq_tmr (loadable 32-bit down-counter with zero flag) SHALL provide DELAY/HIGH/LOW timing.

Verification (DELAY=4, PULSE_W=3, PULSE_GAP=2, PULSE_NUM=3)
REQ-030 Start edge sampled at cycle 0 -> ps_o high cycles 5-7, 10-12, 15-17; ps_done=1 at cycle 18; ps_cnt=3; ps_busy 1..17.
REQ-031 ps_start held high 100 cycles after done -> no second train; drop then raise -> new train, ps_cnt restarts from 1.
REQ-032 ps_start falls at cycle 11 (2nd pulse) -> ps_o=0 and ps_abort=1 at cycle 12, ps_cnt=2, IDLE.
REQ-033 DELAY=0 -> ps_o rises at cycle 1 after start edge sampled at cycle 0.
REQ-034 ps_rst asserted at cycle 6 with ps_start high, released at 9 -> ps_o low immediately, no pulses until ps_start re-rises.
REQ-035 Start edge while in WAIT_REL or during train (glitch low-high within one cycle) -> abort then no restart until next edge in IDLE.
